// File: rtl/sd_init_sequencer.sv
// SD card identification and bring-up sequencer (CMD0..CMD7, ACMD41 polling).
// Define SD_WIDE_BUS_EN to append CMD55/ACMD6 and select the 4-bit data bus.
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES = 74*480,
    parameter int MAX_POLLS      = 1000,
    parameter int POLL_GAP       = 48000
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        init_start,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [3:0]  error_code,
    output logic        card_hcs,
    output logic [15:0] card_rca,
    output logic        fast_clk_en,
    output logic        bus_4bit,
    output logic        cmd_req,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    input  logic        cmd_done,
    input  logic        cmd_timeout,
    input  logic [31:0] cmd_resp_arg
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PWRUP  = 4'd1;
    localparam logic [3:0] S_CMD0   = 4'd2;
    localparam logic [3:0] S_CMD8   = 4'd3;
    localparam logic [3:0] S_CMD55  = 4'd4;
    localparam logic [3:0] S_ACMD41 = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;
    localparam logic [3:0] S_CMD2   = 4'd7;
    localparam logic [3:0] S_CMD3   = 4'd8;
    localparam logic [3:0] S_CMD7   = 4'd9;
    localparam logic [3:0] S_CMD55W = 4'd10;
    localparam logic [3:0] S_ACMD6  = 4'd11;
    localparam logic [3:0] S_DONE   = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;

    logic [3:0]  state;
    logic [31:0] tmr;
    logic [15:0] polls;
    logic        hcs_req;
    logic        is_cmd;
    logic [5:0]  nxt_idx;
    logic [31:0] nxt_arg;
    logic [3:0]  ev_next;
    logic [3:0]  ev_code;
    logic [15:0] polls_inc;

    assign polls_inc = polls + 16'd1;

    always_comb begin
        is_cmd  = 1'b1;
        nxt_idx = 6'd0;
        nxt_arg = 32'd0;
        case (state)
            S_CMD0:   nxt_idx = 6'd0;
            S_CMD8:   begin nxt_idx = 6'd8; nxt_arg = 32'h0000_01AA; end
            S_CMD55:  nxt_idx = 6'd55;
            S_ACMD41: begin
                nxt_idx = 6'd41;
                nxt_arg = {1'b0, hcs_req, 6'b0, 24'hFF8000};
            end
            S_CMD2:   nxt_idx = 6'd2;
            S_CMD3:   nxt_idx = 6'd3;
            S_CMD7:   begin nxt_idx = 6'd7; nxt_arg = {card_rca, 16'h0}; end
            S_CMD55W: begin nxt_idx = 6'd55; nxt_arg = {card_rca, 16'h0}; end
            S_ACMD6:  begin nxt_idx = 6'd6; nxt_arg = 32'd2; end
            default:  is_cmd = 1'b0;
        endcase
    end

    // Outcome of the command currently being waited on.
    always_comb begin
        ev_next = state;
        ev_code = 4'd0;
        case (state)
            S_CMD0: ev_next = S_CMD8;
            S_CMD8:
                if (!cmd_timeout && cmd_resp_arg[7:0] != 8'hAA) begin
                    ev_next = S_ERROR; ev_code = 4'd2;
                end else ev_next = S_CMD55;
            S_CMD55:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd3; end
                else ev_next = S_ACMD41;
            S_ACMD41:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd4; end
                else if (cmd_resp_arg[31]) ev_next = S_CMD2;
                else if (polls_inc == 16'(MAX_POLLS)) begin
                    ev_next = S_ERROR; ev_code = 4'd5;
                end else ev_next = S_GAP;
            S_CMD2:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd6; end
                else ev_next = S_CMD3;
            S_CMD3:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd7; end
                else ev_next = S_CMD7;
            S_CMD7:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd8; end
`ifdef SD_WIDE_BUS_EN
                else ev_next = S_CMD55W;
`else
                else ev_next = S_DONE;
`endif
            S_CMD55W:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd9; end
                else ev_next = S_ACMD6;
            S_ACMD6:
                if (cmd_timeout) begin ev_next = S_ERROR; ev_code = 4'd10; end
                else ev_next = S_DONE;
            default: ;
        endcase
    end

`ifndef SD_WIDE_BUS_EN
    assign bus_4bit = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state        <= S_IDLE;
            tmr          <= 32'd0;
            polls        <= 16'd0;
            hcs_req      <= 1'b0;
            busy         <= 1'b0;
            init_done    <= 1'b0;
            init_error   <= 1'b0;
            error_code   <= 4'd0;
            card_hcs     <= 1'b0;
            card_rca     <= 16'd0;
            fast_clk_en  <= 1'b0;
            cmd_req      <= 1'b0;
            cmd_index    <= 6'd0;
            cmd_argument <= 32'd0;
`ifdef SD_WIDE_BUS_EN
            bus_4bit     <= 1'b0;
`endif
        end else if (is_cmd && cmd_req && cmd_done) begin
            cmd_req <= 1'b0;
            state   <= ev_next;
            tmr     <= 32'd0;
            if (ev_next == S_ERROR) begin
                init_error <= 1'b1;
                error_code <= ev_code;
                busy       <= 1'b0;
            end
            if (ev_next == S_DONE) begin
                init_done   <= 1'b1;
                fast_clk_en <= 1'b1;
                busy        <= 1'b0;
`ifdef SD_WIDE_BUS_EN
                bus_4bit    <= 1'b1;
`endif
            end
            if (state == S_CMD8) hcs_req <= !cmd_timeout;
            if (state == S_ACMD41 && !cmd_timeout) begin
                polls <= polls_inc;
                if (cmd_resp_arg[31]) card_hcs <= cmd_resp_arg[30];
            end
            if (state == S_CMD3 && !cmd_timeout)
                card_rca <= cmd_resp_arg[31:16];
        end else if (is_cmd && !cmd_req) begin
            cmd_req      <= 1'b1;
            cmd_index    <= nxt_idx;
            cmd_argument <= nxt_arg;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR:
                    if (init_start) begin
                        state       <= S_PWRUP;
                        tmr         <= 32'd0;
                        polls       <= 16'd0;
                        busy        <= 1'b1;
                        init_done   <= 1'b0;
                        init_error  <= 1'b0;
                        error_code  <= 4'd0;
                        fast_clk_en <= 1'b0;
`ifdef SD_WIDE_BUS_EN
                        bus_4bit    <= 1'b0;
`endif
                    end
                S_PWRUP:
                    if (tmr == 32'(POWERUP_CYCLES - 1)) begin
                        state <= S_CMD0;
                        tmr   <= 32'd0;
                    end else tmr <= tmr + 32'd1;
                S_GAP:
                    if (tmr == 32'(POLL_GAP - 1)) begin
                        state <= S_CMD55;
                        tmr   <= 32'd0;
                    end else tmr <= tmr + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Self-checking bench for sd_init_sequencer with a behavioural card model.
// Command expectations are queued per scenario and checked as commands issue.
module tb_sd_init_sequencer;

    localparam int PWR  = 20;
    localparam int MAXP = 4;
    localparam int GAP  = 10;

    logic        wb_clk = 0;
    logic        wb_rst = 1;
    logic        init_start = 0;
    logic        busy, init_done, init_error, card_hcs, fast_clk_en, bus_4bit;
    logic [3:0]  error_code;
    logic [15:0] card_rca;
    logic        cmd_req;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        cmd_done = 0;
    logic        cmd_timeout = 0;
    logic [31:0] cmd_resp_arg = 0;

    sd_init_sequencer #(
        .POWERUP_CYCLES(PWR), .MAX_POLLS(MAXP), .POLL_GAP(GAP)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .init_start(init_start),
        .busy(busy), .init_done(init_done), .init_error(init_error),
        .error_code(error_code), .card_hcs(card_hcs), .card_rca(card_rca),
        .fast_clk_en(fast_clk_en), .bus_4bit(bus_4bit),
        .cmd_req(cmd_req), .cmd_index(cmd_index),
        .cmd_argument(cmd_argument), .cmd_done(cmd_done),
        .cmd_timeout(cmd_timeout), .cmd_resp_arg(cmd_resp_arg)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
    } cmd_t;

    typedef struct {
        bit          t8;
        logic [7:0]  r8;
        int          ready_try;
        logic [31:0] ocr;
        bit          exp_done;
        logic [3:0]  exp_code;
        bit          exp_hcs;
    } scen_t;

    cmd_t  q[$];
    scen_t tbl[4];
    int    checks = 0;
    int    failures = 0;
    bit    wide;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] i, input logic [31:0] a);
        cmd_t c;
        c.idx = i;
        c.arg = a;
        q.push_back(c);
    endtask

    task automatic build_queue(input scen_t s);
        int tries;
        bit hcs;
        q.delete();
        push(6'd0, 32'd0);
        push(6'd8, 32'h1AA);
        if (!s.t8 && s.r8 != 8'hAA) return;
        hcs = !s.t8;
        tries = (s.ready_try == 0) ? MAXP : s.ready_try;
        for (int i = 0; i < tries; i++) begin
            push(6'd55, 32'd0);
            push(6'd41, {1'b0, hcs, 6'b0, 24'hFF8000});
        end
        if (s.ready_try == 0) return;
        push(6'd2, 32'd0);
        push(6'd3, 32'd0);
        push(6'd7, 32'h1234_0000);
        if (wide) begin
            push(6'd55, 32'h1234_0000);
            push(6'd6, 32'd2);
        end
    endtask

    // Runs one bring-up with the card model; rst_cmd2 aborts via wb_rst at CMD2.
    task automatic run(input scen_t s, input bit rst_cmd2, input string tag);
        int   k = 0;
        int   ncmd = 0;
        int   tries = 0;
        int   dly = 0;
        bit   served = 0;
        bit   aborted = 0;
        logic [5:0] cur = 0;
        cmd_t c;
        build_queue(s);
        @(negedge wb_clk);
        init_start = 1;
        while (k < 3000) begin
            @(negedge wb_clk);
            k++;
            init_start  = 0;
            cmd_done    = 0;
            cmd_timeout = 0;
            if (k == 3) cmd_done = 1;
            if (!cmd_req) served = 0;
            else if (!served) begin
                served = 1;
                ncmd++;
                cur = cmd_index;
                dly = 2;
                if (ncmd == 1) chk({tag, " first_cmd_cycle"}, k, PWR + 2);
                if (cmd_index == 6'd41) tries++;
                if (q.size() == 0) begin
                    chk({tag, " extra_cmd"}, cmd_index, 6'h3F);
                end else begin
                    c = q.pop_front();
                    chk({tag, " cmd_index"}, cmd_index, c.idx);
                    chk({tag, " cmd_arg"}, cmd_argument, c.arg);
                end
                if (ncmd == 4) init_start = 1;
                if (rst_cmd2 && cmd_index == 6'd2) begin
                    wb_rst = 1;
                    aborted = 1;
                    break;
                end
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    cmd_done = 1;
                    cmd_resp_arg = 32'd0;
                    case (cur)
                        6'd0: cmd_timeout = 1;
                        6'd8: begin
                            cmd_timeout = s.t8;
                            cmd_resp_arg = {24'h000001, s.r8};
                        end
                        6'd55: cmd_resp_arg = 32'h120;
                        6'd41: cmd_resp_arg = (tries == s.ready_try) ?
                                   s.ocr : (s.ocr & 32'h7FFF_FFFF);
                        6'd3: cmd_resp_arg = 32'h1234_0000;
                        default: ;
                    endcase
                end
            end
            if (!busy && k > 1) break;
        end
        cmd_done = 0;
        cmd_timeout = 0;
        if (aborted) begin
            @(negedge wb_clk);
            chk({tag, " rst_cmd_req"}, cmd_req, 1'b0);
            chk({tag, " rst_busy"}, busy, 1'b0);
            wb_rst = 0;
            q.delete();
            return;
        end
        chk({tag, " finished_in_budget"}, k < 3000, 1'b1);
        chk({tag, " queue_empty"}, q.size(), 0);
        chk({tag, " init_done"}, init_done, s.exp_done);
        chk({tag, " init_error"}, init_error, !s.exp_done);
        chk({tag, " error_code"}, error_code, s.exp_code);
        chk({tag, " fast_clk_en"}, fast_clk_en, s.exp_done);
        chk({tag, " bus_4bit"}, bus_4bit, s.exp_done && wide);
        if (s.exp_done) begin
            chk({tag, " card_hcs"}, card_hcs, s.exp_hcs);
            chk({tag, " card_rca"}, card_rca, 16'h1234);
        end
        begin
            bit seen = 0;
            repeat (20) begin
                @(negedge wb_clk);
                if (cmd_req || busy) seen = 1;
            end
            chk({tag, " quiet_after_end"}, seen, 1'b0);
        end
    endtask

    initial begin
`ifdef SD_WIDE_BUS_EN
        wide = 1;
`else
        wide = 0;
`endif
        tbl[0] = '{t8:0, r8:8'hAA, ready_try:3, ocr:32'hC0FF8000,
                   exp_done:1, exp_code:4'd0, exp_hcs:1};
        tbl[1] = '{t8:1, r8:8'h00, ready_try:3, ocr:32'h80FF8000,
                   exp_done:1, exp_code:4'd0, exp_hcs:0};
        tbl[2] = '{t8:0, r8:8'h55, ready_try:3, ocr:32'hC0FF8000,
                   exp_done:0, exp_code:4'd2, exp_hcs:0};
        tbl[3] = '{t8:0, r8:8'hAA, ready_try:0, ocr:32'hC0FF8000,
                   exp_done:0, exp_code:4'd5, exp_hcs:0};

        repeat (3) @(negedge wb_clk);
        chk("reset busy", busy, 1'b0);
        chk("reset init_done", init_done, 1'b0);
        chk("reset init_error", init_error, 1'b0);
        chk("reset error_code", error_code, 4'd0);
        chk("reset cmd_req", cmd_req, 1'b0);
        chk("reset cmd_index", cmd_index, 6'd0);
        chk("reset cmd_argument", cmd_argument, 32'd0);
        chk("reset card_rca", card_rca, 16'd0);
        chk("reset card_hcs", card_hcs, 1'b0);
        chk("reset fast_clk_en", fast_clk_en, 1'b0);
        chk("reset bus_4bit", bus_4bit, 1'b0);
        wb_rst = 0;

        for (int i = 0; i < 4; i++) run(tbl[i], 1'b0, $sformatf("scen%0d", i));

        run(tbl[0], 1'b1, "rst_cmd2");
        run(tbl[0], 1'b0, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
